// File: rtl/fb_write_arbiter.sv
// Frame-buffer RAM write-port arbiter: clear sequencer, then round-robin host/aux.
// Latency: grant in cycle N drives the RAM port in N+1; backpressure is grant=0 (requester holds).
package types;
    typedef logic [11:0] mem_write_addr_t;
    typedef logic [15:0] mem_write_data_t;
endpackage

module fb_write_arbiter #(
    parameter types::mem_write_addr_t CLEAR_LAST_ADDR = types::mem_write_addr_t'('1),
    parameter int                     _UNUSED         = 0
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    clear_start,
    input  types::mem_write_data_t  clear_value,
    output logic                    clear_busy,
    output logic                    clear_done,
    input  logic                    host_req,
    input  types::mem_write_addr_t  host_addr,
    input  types::mem_write_data_t  host_data,
    output logic                    host_grant,
    input  logic                    aux_req,
    input  types::mem_write_addr_t  aux_addr,
    input  types::mem_write_data_t  aux_data,
    output logic                    aux_grant,
    output logic                    ram_write_enable,
    output types::mem_write_addr_t  ram_address,
    output types::mem_write_data_t  ram_data_out
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    types::mem_write_addr_t r_clear_addr;
    types::mem_write_data_t r_clear_value;
    logic                   r_last_aux;
    logic                   r_clear_done;
    logic                   r_we;
    types::mem_write_addr_t r_addr;
    types::mem_write_data_t r_data;

    logic                   w_host_win;
    logic                   w_aux_win;
    logic                   w_clear_wr;
    logic                   w_busy;
    logic                   w_wr_en;
    types::mem_write_addr_t w_wr_addr;
    types::mem_write_data_t w_wr_data;
    logic                   w_clear_last;

    if (_UNUSED != 0) begin : g_placeholder
    end

    // Termination compares against the last address, so an all-ones limit never relies on carry-out.
    assign w_clear_last = (r_clear_addr == CLEAR_LAST_ADDR);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_start)  w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clear_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_host_win = 1'b0;
        w_aux_win  = 1'b0;
        w_clear_wr = 1'b0;
        w_busy     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    // A clear request steals the cycle it is seen in, so nobody else is granted.
                    if (!clear_start) begin
                        if (host_req && (!aux_req || r_last_aux)) begin
                            w_host_win = 1'b1;
                        end else if (aux_req) begin
                            w_aux_win = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    w_clear_wr = 1'b1;
                    w_busy     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wr_en   = w_host_win | w_aux_win | w_clear_wr;
        w_wr_addr = r_clear_addr;
        w_wr_data = r_clear_value;
        if (w_host_win) begin
            w_wr_addr = host_addr;
            w_wr_data = host_data;
        end else if (w_aux_win) begin
            w_wr_addr = aux_addr;
            w_wr_data = aux_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_clear_addr  <= '0;
            r_clear_value <= '0;
            r_last_aux    <= 1'b1;
            r_clear_done  <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
        end else begin
            r_clear_done <= w_clear_wr & w_clear_last;
            if (r_state == S_IDLE && clear_start) begin
                r_clear_addr  <= '0;
                r_clear_value <= clear_value;
            end else if (w_clear_wr) begin
                r_clear_addr <= r_clear_addr + types::mem_write_addr_t'(1);
            end
            if (w_host_win) begin
                r_last_aux <= 1'b0;
            end else if (w_aux_win) begin
                r_last_aux <= 1'b1;
            end
            r_we <= w_wr_en;
            if (w_wr_en) begin
                r_addr <= w_wr_addr;
                r_data <= w_wr_data;
            end
        end
    end

    assign clear_busy       = w_busy;
    assign clear_done       = r_clear_done;
    assign host_grant       = w_host_win;
    assign aux_grant        = w_aux_win;
    assign ram_write_enable = r_we;
    assign ram_address      = r_addr;
    assign ram_data_out     = r_data;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus random traffic against a write-list model.
module tb_fb_write_arbiter;

    localparam types::mem_write_addr_t LAST = 12'd7;
    typedef logic [32:0] obs_t; // {hg, ag, busy, done, we, addr[11:0], data[15:0]}

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clear_start;
    types::mem_write_data_t clear_value;
    logic                   clear_busy, clear_done;
    logic                   host_req, aux_req;
    types::mem_write_addr_t host_addr, aux_addr;
    types::mem_write_data_t host_data, aux_data;
    logic                   host_grant, aux_grant;
    logic                   ram_write_enable;
    types::mem_write_addr_t ram_address;
    types::mem_write_data_t ram_data_out;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.CLEAR_LAST_ADDR(LAST), ._UNUSED(0)) dut (
        .clk_in(clk), .reset(reset),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_grant(host_grant),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data), .aux_grant(aux_grant),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address), .ram_data_out(ram_data_out)
    );

    // Model: a clear is "N writes still owed"; otherwise the port alternates on ties.
    int                     m_left = 0;
    types::mem_write_addr_t m_caddr = '0;
    types::mem_write_data_t m_cval = '0;
    bit                     m_last_aux = 1'b1;
    bit                     m_done = 1'b0, m_we = 1'b0;
    types::mem_write_addr_t m_addr = '0;
    types::mem_write_data_t m_data = '0;

    function automatic obs_t exp_now();
        bit hg = 1'b0, ag = 1'b0, busy;
        busy = !reset && (m_left > 0);
        if (!reset && m_left == 0 && !clear_start) begin
            if (host_req && (!aux_req || m_last_aux)) hg = 1'b1;
            else if (aux_req) ag = 1'b1;
        end
        return {hg, ag, busy, m_done, m_we, m_addr, m_data};
    endfunction

    task automatic model_edge(input bit hg, input bit ag);
        if (reset) begin
            m_left = 0; m_caddr = '0; m_cval = '0; m_last_aux = 1'b1;
            m_done = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
            return;
        end
        m_done = 1'b0;
        m_we   = 1'b0;
        if (m_left > 0) begin
            m_we = 1'b1; m_addr = m_caddr; m_data = m_cval;
            m_left--;
            m_done = (m_left == 0);
            m_caddr = m_caddr + 12'd1;
        end else if (clear_start) begin
            m_left = int'(LAST) + 1; m_caddr = '0; m_cval = clear_value;
        end else if (hg) begin
            m_we = 1'b1; m_addr = host_addr; m_data = host_data; m_last_aux = 1'b0;
        end else if (ag) begin
            m_we = 1'b1; m_addr = aux_addr; m_data = aux_data; m_last_aux = 1'b1;
        end
    endtask

    task automatic tick(output obs_t o, output obs_t e);
        @(negedge clk);
        o = {host_grant, aux_grant, clear_busy, clear_done, ram_write_enable, ram_address, ram_data_out};
        e = exp_now();
        @(posedge clk);
        model_edge(e[32], e[31]);
        #1;
    endtask

    task automatic idle_inputs();
        clear_start = 1'b0; host_req = 1'b0; aux_req = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b1; clear_start = 1'b1; host_req = 1'b1; aux_req = 1'b1;
        clear_value = 16'hFFFF; host_addr = 12'h001; host_data = 16'h1111;
        aux_addr = 12'h002; aux_data = 16'h2222;
        @(posedge clk);
        model_edge(1'b0, 1'b0);
        #1;
        tick(o, e);
        checks++;
        if (o !== 33'd0) $display("FAIL reset_outputs got %h want 0", o);
        else passes++;
        reset = 1'b0; clear_start = 1'b0;
        tick(o, e);
        checks++;
        if (o[32] !== 1'b1 || o[31] !== 1'b0) $display("FAIL reset_first_tie got hg=%b ag=%b want hg=1 ag=0", o[32], o[31]);
        else passes++;
        idle_inputs();
        tick(o, e);
    endtask

    task automatic test_host_only();
        obs_t o, e;
        types::mem_write_addr_t wa[$];
        types::mem_write_data_t wd[$];
        host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) host_req = 1'b0;
            host_addr = 12'h010 + 12'(i);
            host_data = 16'h00A1 + 16'(i);
            tick(o, e);
            if (o[28]) begin wa.push_back(o[27:16]); wd.push_back(o[15:0]); end
            checks++;
            if (o !== e) $display("FAIL host_only cyc %0d got %h want %h", i, o, e);
            else passes++;
            if (i < 3) begin
                checks++;
                if (o[32] !== 1'b1) $display("FAIL host_only_grant cyc %0d got %b want 1", i, o[32]);
                else passes++;
            end
        end
        checks++;
        if (wa.size() != 3 || wa[0] !== 12'h010 || wa[1] !== 12'h011 || wa[2] !== 12'h012 ||
            wd[0] !== 16'h00A1 || wd[1] !== 16'h00A2 || wd[2] !== 16'h00A3)
            $display("FAIL host_only_writes got n=%0d want 3 writes 010/A1..012/A3", wa.size());
        else passes++;
    endtask

    task automatic test_contention();
        obs_t o, e;
        string got = "", want = "";
        aux_req = 1'b1; aux_addr = 12'h030; aux_data = 16'h0B00;
        tick(o, e);
        host_req = 1'b1; host_addr = 12'h020; host_data = 16'h0C00;
        aux_addr = 12'h031; aux_data = 16'h0B01;
        for (int i = 0; i < 7; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) $display("FAIL contention cyc %0d got %h want %h", i, o, e);
            else passes++;
            if (i < 6) begin
                got  = {got, o[32] ? "H" : (o[31] ? "A" : "-")};
                want = {want, (i % 2 == 0) ? "H" : "A"};
            end
            if (i >= 1) begin
                checks++;
                if (o[28] !== 1'b1 || o[27:16] !== (((i - 1) % 2 == 0) ? 12'h020 : 12'h031) + 12'((i - 1) / 2))
                    $display("FAIL contention_ram cyc %0d got we=%b addr=%h", i, o[28], o[27:16]);
                else passes++;
            end
            if (o[32]) begin host_addr = host_addr + 12'd1; host_data = host_data + 16'd1; end
            if (o[31]) begin aux_addr = aux_addr + 12'd1; aux_data = aux_data + 16'd1; end
            if (i == 5) aux_req = 1'b0;
        end
        checks++;
        if (got != want) $display("FAIL contention_order got %s want %s", got, want);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            checks++;
            if (o[32] !== 1'b1 || o !== e) $display("FAIL host_back_to_back cyc %0d got %h want %h", i, o, e);
            else passes++;
        end
        idle_inputs();
        tick(o, e);
    endtask

    task automatic test_clear(input bit pulse_again);
        obs_t o, e;
        int busy_n = 0, done_n = 0, clr_n = 0, hg_n = 0, bad = 0;
        bit after_last = 1'b0, host_follow = 1'b0;
        types::mem_write_addr_t nxt = '0;
        host_req = !pulse_again; host_addr = 12'h040; host_data = 16'h1234;
        clear_value = 16'h005A; clear_start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(o, e);
            clear_start = 1'b0;
            if (pulse_again && i == 3) begin clear_start = 1'b1; clear_value = 16'h0077; end
            else clear_value = 16'h00EE;
            checks++;
            if (o !== e) $display("FAIL clear cyc %0d got %h want %h", i, o, e);
            else passes++;
            if (after_last) host_follow = o[28] && o[27:16] == 12'h040 && o[15:0] == 16'h1234;
            after_last = 1'b0;
            busy_n += int'(o[30]);
            done_n += int'(o[29]);
            if (o[30] || i == 0) hg_n += int'(o[32]);
            if (o[28] && o[15:0] != 16'h1234) begin
                clr_n++;
                if (o[15:0] != 16'h005A || o[27:16] != nxt) bad++;
                if (o[27:16] == LAST) after_last = 1'b1;
                nxt = nxt + 12'd1;
            end
        end
        checks++;
        if (busy_n != 8) $display("FAIL clear_busy_len got %0d want 8", busy_n); else passes++;
        checks++;
        if (clr_n != 8 || bad != 0) $display("FAIL clear_writes got %0d (bad %0d) want 8 (bad 0)", clr_n, bad); else passes++;
        checks++;
        if (done_n != 1) $display("FAIL clear_done_pulses got %0d want 1", done_n); else passes++;
        checks++;
        if (hg_n != 0) $display("FAIL clear_host_blocked got %0d grants want 0", hg_n); else passes++;
        if (!pulse_again) begin
            checks++;
            if (!host_follow) $display("FAIL clear_host_no_gap got 0 want 1"); else passes++;
        end
        idle_inputs();
        tick(o, e);
    endtask

    task automatic test_reset_mid_clear();
        obs_t o, e;
        int wr = 0, late = 0, budget = 0;
        clear_value = 16'h0033; clear_start = 1'b1;
        while (wr < 3 && budget < 20) begin
            tick(o, e);
            clear_start = 1'b0;
            wr += int'(o[28]);
            budget++;
        end
        checks++;
        if (wr != 3) $display("FAIL midclear_wait got %0d writes want 3", wr); else passes++;
        reset = 1'b1;
        tick(o, e);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(o, e);
            late += int'(o[28]) + int'(o[30]);
            checks++;
            if (o !== e) $display("FAIL midclear_after cyc %0d got %h want %h", i, o, e); else passes++;
        end
        checks++;
        if (late != 0) $display("FAIL midclear_aborted got %0d busy/write cycles want 0", late); else passes++;
        clear_value = 16'h0044; clear_start = 1'b1;
        tick(o, e);
        clear_start = 1'b0;
        tick(o, e);
        tick(o, e);
        checks++;
        if (o[28] !== 1'b1 || o[27:16] !== 12'h000 || o[15:0] !== 16'h0044)
            $display("FAIL midclear_restart got we=%b addr=%h data=%h want 1/000/0044", o[28], o[27:16], o[15:0]);
        else passes++;
        for (int i = 0; i < 10; i++) tick(o, e);
    endtask

    task automatic test_random();
        obs_t o, e;
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            clear_start = ($urandom_range(0, 49) == 0);
            clear_value = 16'($urandom);
            tick(o, e);
            checks++;
            if (o !== e) begin
                errs++;
                if (errs < 10) $display("FAIL random cyc %0d got %h want %h", i, o, e);
            end else passes++;
            if (!host_req || e[32]) begin
                host_req = 1'($urandom); host_addr = 12'($urandom); host_data = 16'($urandom);
            end
            if (!aux_req || e[31]) begin
                aux_req = 1'($urandom); aux_addr = 12'($urandom); aux_data = 16'($urandom);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_host_only();
        test_contention();
        test_clear(1'b0);
        test_clear(1'b1);
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
